// File: rtl/dnn_result_collector.sv
// Pairs the two DNN output-layer scores and computes argmax, score and margin.
// Results queue in a small FIFO and leave on a valid/ready interface.
module dnn_result_collector #(
   parameter int W     = 17,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [W-1:0]               out0,
   input  logic [W-1:0]               out1,
   input  logic                       out0_ready,
   input  logic                       out1_ready,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       res_class,
   output logic [W-1:0]               res_score,
   output logic [W:0]                 res_margin,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       err_ovf,
   output logic                       err_sync
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  hold0, hold1;
   logic          have0, have1;
   logic          pair, sync_hit;
   logic [W-1:0]  a0, a1;
   logic [W:0]    diff;
   logic          n_class;
   logic [W-1:0]  n_score;
   logic [W:0]    n_margin;

   logic          mem_cls [DEPTH];
   logic [W-1:0]  mem_sc  [DEPTH];
   logic [W:0]    mem_mg  [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_nx;
   logic          full, pop, push;

   // Incoming values take priority; a held half fills the missing side.
   always_comb begin
      pair = 1'b0;
      a0   = out0;
      a1   = out1;
      if (out0_ready && out1_ready) begin
         pair = 1'b1;
      end else if (out0_ready && have1) begin
         pair = 1'b1;
         a1   = hold1;
      end else if (out1_ready && have0) begin
         pair = 1'b1;
         a0   = hold0;
      end
   end

   assign sync_hit =
      (out0_ready && out1_ready && (have0 || have1)) ||
      (out0_ready && !out1_ready && !have1 && have0) ||
      (out1_ready && !out0_ready && !have0 && have1);

   assign diff     = {a0[W-1], a0} - {a1[W-1], a1};
   assign n_class  = diff[W];
   assign n_score  = n_class ? a1 : a0;
   assign n_margin = diff[W] ? (~diff + 1'b1) : diff;

   assign res_valid = (fifo_count != '0);
   assign full      = (fifo_count == CW'(DEPTH));
   assign pop       = res_valid && res_ready;
   assign push      = pair && (!full || pop);
   assign rd_nx     = rd_ptr + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold0 <= '0;
         hold1 <= '0;
         have0 <= 1'b0;
         have1 <= 1'b0;
      end else if (pair) begin
         have0 <= 1'b0;
         have1 <= 1'b0;
      end else begin
         if (out0_ready) begin
            hold0 <= out0;
            have0 <= 1'b1;
         end
         if (out1_ready) begin
            hold1 <= out1;
            have1 <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_cls[wr_ptr] <= n_class;
         mem_sc[wr_ptr]  <= n_score;
         mem_mg[wr_ptr]  <= n_margin;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         err_ovf    <= 1'b0;
         err_sync   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_nx;
         if (push && !pop)
            fifo_count <= fifo_count + 1'b1;
         else if (pop && !push)
            fifo_count <= fifo_count - 1'b1;
         if (pair && full && !pop) err_ovf <= 1'b1;
         if (sync_hit) err_sync <= 1'b1;
      end
   end

   // Head registers track the entry at rd_ptr; they hold when the FIFO empties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_class  <= 1'b0;
         res_score  <= '0;
         res_margin <= '0;
      end else if (pop && fifo_count > CW'(1)) begin
         res_class  <= mem_cls[rd_nx];
         res_score  <= mem_sc[rd_nx];
         res_margin <= mem_mg[rd_nx];
      end else if (push && (pop || !res_valid)) begin
         res_class  <= n_class;
         res_score  <= n_score;
         res_margin <= n_margin;
      end
   end

endmodule

// File: tb/tb_dnn_result_collector.sv
// Directed and randomized checks of dnn_result_collector against a
// queue-based reference model.
module tb_dnn_result_collector;

   localparam int W     = 17;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  out0, out1;
   logic          out0_ready, out1_ready;
   logic          res_valid, res_ready;
   logic          res_class;
   logic [W-1:0]  res_score;
   logic [W:0]    res_margin;
   logic [CW-1:0] fifo_count;
   logic          err_ovf, err_sync;

   dnn_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .out0       (out0),
      .out1       (out1),
      .out0_ready (out0_ready),
      .out1_ready (out1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_class  (res_class),
      .res_score  (res_score),
      .res_margin (res_margin),
      .fifo_count (fifo_count),
      .err_ovf    (err_ovf),
      .err_sync   (err_sync)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int q_cls[$], q_sc[$], q_mg[$];
   bit hv0, hv1, m_ovf, m_sync;
   int h0, h1, m_cls, m_sc, m_mg;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q_cls.delete(); q_sc.delete(); q_mg.delete();
      hv0 = 0; hv1 = 0; h0 = 0; h1 = 0;
      m_ovf = 0; m_sync = 0;
      m_cls = 0; m_sc = 0; m_mg = 0;
   endtask

   task automatic model_step();
      bit p0, p1, pr, pop;
      int v0, v1, a0, a1;
      p0 = out0_ready; p1 = out1_ready;
      v0 = $signed(out0); v1 = $signed(out1);
      pr = 0; a0 = v0; a1 = v1;
      if (p0 && p1) begin
         if (hv0 || hv1) m_sync = 1;
         pr = 1;
      end else if (p0) begin
         if (hv1) begin pr = 1; a1 = h1; end
         else begin
            if (hv0) m_sync = 1;
            h0 = v0; hv0 = 1;
         end
      end else if (p1) begin
         if (hv0) begin pr = 1; a0 = h0; end
         else begin
            if (hv1) m_sync = 1;
            h1 = v1; hv1 = 1;
         end
      end
      if (pr) begin hv0 = 0; hv1 = 0; end
      pop = (q_cls.size() > 0) && res_ready;
      if (pop) begin
         void'(q_cls.pop_front());
         void'(q_sc.pop_front());
         void'(q_mg.pop_front());
      end
      if (pr) begin
         if (q_cls.size() < DEPTH) begin
            q_cls.push_back(a1 > a0 ? 1 : 0);
            q_sc.push_back(a1 > a0 ? a1 : a0);
            q_mg.push_back(a0 > a1 ? a0 - a1 : a1 - a0);
         end else m_ovf = 1;
      end
      if (q_cls.size() > 0) begin
         m_cls = q_cls[0]; m_sc = q_sc[0]; m_mg = q_mg[0];
      end
   endtask

   task automatic compare();
      check("valid",  res_valid, q_cls.size() > 0);
      check("count",  fifo_count, q_cls.size());
      check("ovf",    err_ovf, m_ovf);
      check("sync",   err_sync, m_sync);
      check("class",  res_class, m_cls);
      check("score",  $signed(res_score), m_sc);
      check("margin", res_margin, m_mg);
   endtask

   task automatic tick(input bit p0, input int v0,
                       input bit p1, input int v1, input bit rr);
      out0_ready = p0; out0 = v0[W-1:0];
      out1_ready = p1; out1 = v1[W-1:0];
      res_ready  = rr;
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, rr);
   endtask

   task automatic async_reset();
      out0_ready = 0; out1_ready = 0;
      #2 rst = 1;
      #1;
      model_reset();
      check("rst_valid", res_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf",   err_ovf, 0);
      check("rst_sync",  err_sync, 0);
      @(posedge clk);
      #1 rst = 0;
      compare();
   endtask

   initial begin
      rst = 1; out0 = '0; out1 = '0;
      out0_ready = 0; out1_ready = 0; res_ready = 0;
      model_reset();
      #12;
      compare();
      rst = 0;

      tick(1, 100, 1, -20, 0);
      check("t1_valid",  res_valid, 1);
      check("t1_class",  res_class, 0);
      check("t1_score",  $signed(res_score), 100);
      check("t1_margin", res_margin, 120);
      idle(2, 1);

      tick(0, 0, 1, 50, 0);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 0, 0);
         check("t2_early", res_valid, 0);
      end
      tick(1, 7, 0, 0, 0);
      check("t2_class",  res_class, 1);
      check("t2_score",  $signed(res_score), 50);
      check("t2_margin", res_margin, 43);
      check("t2_count",  fifo_count, 1);
      idle(2, 1);

      tick(1, -5, 1, -5, 0);
      check("t3_tclass",  res_class, 0);
      check("t3_tmargin", res_margin, 0);
      tick(1, -65536, 1, 65535, 1);
      check("t3_class",  res_class, 1);
      check("t3_score",  $signed(res_score), 65535);
      check("t3_margin", res_margin, 131071);
      idle(2, 1);

      for (int i = 1; i <= DEPTH; i++) tick(1, i * 10, 1, -i, 0);
      check("t4_full", fifo_count, DEPTH);
      tick(1, 1, 1, 2, 1);
      check("t4_pp_count", fifo_count, DEPTH);
      check("t4_pp_ovf",   err_ovf, 0);
      tick(1, 3, 1, 4, 0);
      check("t4_ovf",   err_ovf, 1);
      check("t4_count", fifo_count, DEPTH);
      idle(DEPTH + 1, 1);
      check("t4_empty", res_valid, 0);

      tick(1, 10, 0, 0, 0);
      tick(1, 30, 0, 0, 0);
      tick(0, 0, 1, 20, 0);
      check("t5_sync",   err_sync, 1);
      check("t5_class",  res_class, 0);
      check("t5_score",  $signed(res_score), 30);
      check("t5_margin", res_margin, 10);
      idle(1, 1);

      tick(1, 5, 1, 6, 0);
      tick(1, 8, 1, 2, 0);
      tick(0, 0, 1, 77, 0);
      async_reset();
      tick(0, 0, 1, 9, 0);
      idle(2, 0);
      check("t6_noentry", res_valid, 0);

      for (int c = 0; c < 800; c++) begin
         int v0, v1;
         v0 = int'($urandom_range(0, 131071)) - 65536;
         v1 = int'($urandom_range(0, 131071)) - 65536;
         if (c % 200 == 199) async_reset();
         tick($urandom_range(0, 2) == 0, v0,
              $urandom_range(0, 2) == 0, v1,
              (c / 40) % 2 == 0 ? 1'b1 : ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
